// File: rtl/hs_mon_pkg.sv
// Shared types and helpers for the ready/valid handshake protocol monitor.
package hs_mon_pkg;

    typedef enum logic [0:0] {
        HS_IDLE  = 1'b0,
        HS_STALL = 1'b1
    } hs_state_e;

    // Per-channel error events, valid for one cycle (the offending sampled edge).
    typedef struct packed {
        logic drop;
        logic data;
        logic timeout;
    } hs_err_t;

    // Saturating increment; callers zero-extend their counter and cast the result back.
    function automatic logic [31:0] sat_inc(input logic [31:0] val, input logic [31:0] max_val);
        return (val >= max_val) ? max_val : val + 32'd1;
    endfunction

endpackage

// File: rtl/hs_channel_checker.sv
// One ready/valid channel: stall FSM, held payload, stall counter and transfer counter.
// Emits single-cycle error events; stickiness lives in the top level.
module hs_channel_checker
    import hs_mon_pkg::*;
#(
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_i,
    input  logic              valid_i,
    input  logic              ready_i,
    input  logic [DATA_W-1:0] data_i,
    output hs_err_t           err_o,
    output logic [CNT_W-1:0]  xfer_count_o
);

    // With the timeout disabled the counter still needs a legal saturation point.
    localparam int unsigned StallMax = (TIMEOUT == 0) ? 1 : TIMEOUT;
    localparam int unsigned StallW   = $clog2(StallMax + 1);

    hs_state_e          state_q, state_d;
    logic [DATA_W-1:0]  hold_q, hold_d;
    logic [StallW-1:0]  stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0]   xfer_q, xfer_d;

    // Next-state logic and error-event decode for the stall FSM.
    always_comb begin
        state_d     = state_q;
        hold_d      = hold_q;
        stall_cnt_d = stall_cnt_q;
        err_o       = '0;
        unique case (state_q)
            HS_IDLE: begin
                if (valid_i && !ready_i) begin
                    state_d       = HS_STALL;
                    hold_d        = data_i;
                    stall_cnt_d   = StallW'(1);
                    err_o.timeout = (TIMEOUT == 32'd1);
                end
            end
            HS_STALL: begin
                // Compared against the payload captured at stall entry, including
                // on the cycle that finally completes the transfer.
                if (valid_i && (data_i != hold_q)) begin
                    err_o.data = 1'b1;
                end
                if (!valid_i) begin
                    state_d     = HS_IDLE;
                    stall_cnt_d = '0;
                    err_o.drop  = 1'b1;
                end else if (ready_i) begin
                    state_d     = HS_IDLE;
                    stall_cnt_d = '0;
                end else begin
                    stall_cnt_d   = StallW'(sat_inc(32'(stall_cnt_q), StallMax));
                    // Fires only on the step that reaches TIMEOUT, so once per stall.
                    err_o.timeout = (TIMEOUT != 0) && (32'(stall_cnt_q) < TIMEOUT) &&
                                    (32'(stall_cnt_d) == TIMEOUT);
                end
            end
            default: state_d = HS_IDLE;
        endcase
    end

    // Saturating count of completed transfers, zeroed by clear.
    always_comb begin
        xfer_d = xfer_q;
        if (clear_i) begin
            xfer_d = '0;
        end else if (valid_i && ready_i) begin
            xfer_d = CNT_W'(sat_inc(32'(xfer_q), 32'({CNT_W{1'b1}})));
        end
    end

    // FSM, held payload and stall counter registers.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= HS_IDLE;
            hold_q      <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            hold_q      <= hold_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Transfer counter register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            xfer_q <= '0;
        end else begin
            xfer_q <= xfer_d;
        end
    end

    assign xfer_count_o = xfer_q;

endmodule

// File: rtl/handshake_protocol_monitor.sv
// Ready/valid protocol monitor for N_CH channels: per-channel checkers, sticky error
// flags, registered error summary and first-failing-channel capture.
module handshake_protocol_monitor
    import hs_mon_pkg::*;
#(
    parameter int unsigned N_CH    = 3,
    parameter int unsigned DATA_W  = 4,
    parameter int unsigned TIMEOUT = 16,
    parameter int unsigned CNT_W   = 16
) (
    input  logic                     CLK,
    input  logic                     ASYNCRESET,
    input  logic                     clear,
    input  logic [N_CH-1:0]          ch_valid,
    input  logic [N_CH-1:0]          ch_ready,
    input  logic [N_CH*DATA_W-1:0]   ch_data,
    output logic [N_CH-1:0]          err_drop,
    output logic [N_CH-1:0]          err_data,
    output logic [N_CH-1:0]          err_timeout,
    output logic                     any_err,
    output logic [$clog2(N_CH):0]    first_err_ch,
    output logic [N_CH*CNT_W-1:0]    xfer_count
);

    // MSB of first_err_ch is the valid flag, the rest is the channel index.
    localparam int unsigned FeW = $clog2(N_CH) + 1;

    logic [N_CH-1:0] evt_drop, evt_data, evt_to;
    logic [N_CH-1:0] drop_q, drop_d;
    logic [N_CH-1:0] data_q, data_d;
    logic [N_CH-1:0] to_q, to_d;
    logic            any_err_q, any_err_d;
    logic [FeW-1:0]  first_q, first_d;
    logic [N_CH-1:0] evt_any;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        hs_err_t ch_err;

        hs_channel_checker #(
            .DATA_W  (DATA_W),
            .TIMEOUT (TIMEOUT),
            .CNT_W   (CNT_W)
        ) u_chk (
            .clk_i        (CLK),
            .rst_i        (ASYNCRESET),
            .clear_i      (clear),
            .valid_i      (ch_valid[g]),
            .ready_i      (ch_ready[g]),
            .data_i       (ch_data[g*DATA_W +: DATA_W]),
            .err_o        (ch_err),
            .xfer_count_o (xfer_count[g*CNT_W +: CNT_W])
        );

        assign evt_drop[g] = ch_err.drop;
        assign evt_data[g] = ch_err.data;
        assign evt_to[g]   = ch_err.timeout;
    end

    // Sticky accumulation, summary flag and lowest-index first-error capture.
    always_comb begin
        evt_any   = evt_drop | evt_data | evt_to;
        drop_d    = clear ? '0 : (drop_q | evt_drop);
        data_d    = clear ? '0 : (data_q | evt_data);
        to_d      = clear ? '0 : (to_q | evt_to);
        // Built from next-state so it rises together with the individual flags.
        any_err_d = |{drop_d, data_d, to_d};
        first_d   = first_q;
        if (clear) begin
            first_d = '0;
        end else if (!first_q[FeW-1]) begin
            // Descending scan so the lowest flagged index is written last.
            for (int i = int'(N_CH) - 1; i >= 0; i--) begin
                if (evt_any[i]) begin
                    first_d          = FeW'(i);
                    first_d[FeW-1]   = 1'b1;
                end
            end
        end
    end

    // Sticky error and summary registers.
    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            drop_q    <= '0;
            data_q    <= '0;
            to_q      <= '0;
            any_err_q <= 1'b0;
            first_q   <= '0;
        end else begin
            drop_q    <= drop_d;
            data_q    <= data_d;
            to_q      <= to_d;
            any_err_q <= any_err_d;
            first_q   <= first_d;
        end
    end

    assign err_drop     = drop_q;
    assign err_data     = data_q;
    assign err_timeout  = to_q;
    assign any_err      = any_err_q;
    assign first_err_ch = first_q;

endmodule

// File: tb/tb_handshake_protocol_monitor.sv
// Self-checking bench: directed scenarios plus randomized traffic against a
// stall-length based reference model.
module tb_handshake_protocol_monitor;

    localparam int N_CH    = 3;
    localparam int DATA_W  = 4;
    localparam int TIMEOUT = 4;
    localparam int CNT_W   = 3;
    localparam int CNT_MAX = 7;

    logic        CLK = 1'b0;
    logic        ASYNCRESET = 1'b1;
    logic        clear = 1'b0;
    logic [2:0]  ch_valid = '0;
    logic [2:0]  ch_ready = '0;
    logic [11:0] ch_data = '0;
    logic [2:0]  err_drop, err_data, err_timeout;
    logic        any_err;
    logic [2:0]  first_err_ch;
    logic [8:0]  xfer_count;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: stall length in cycles, payload at stall start, sticky flags.
    int m_stall_len[3];
    int m_held[3];
    bit m_drop[3], m_data[3], m_to[3];
    int m_cnt[3];
    bit m_fe_v;
    int m_fe_idx;

    handshake_protocol_monitor #(
        .N_CH    (N_CH),
        .DATA_W  (DATA_W),
        .TIMEOUT (TIMEOUT),
        .CNT_W   (CNT_W)
    ) dut (
        .CLK          (CLK),
        .ASYNCRESET   (ASYNCRESET),
        .clear        (clear),
        .ch_valid     (ch_valid),
        .ch_ready     (ch_ready),
        .ch_data      (ch_data),
        .err_drop     (err_drop),
        .err_data     (err_data),
        .err_timeout  (err_timeout),
        .any_err      (any_err),
        .first_err_ch (first_err_ch),
        .xfer_count   (xfer_count)
    );

    always #5 CLK = ~CLK;

    function automatic void model_reset();
        for (int c = 0; c < 3; c++) begin
            m_stall_len[c] = 0;
            m_held[c]      = 0;
            m_drop[c]      = 0;
            m_data[c]      = 0;
            m_to[c]        = 0;
            m_cnt[c]       = 0;
        end
        m_fe_v   = 0;
        m_fe_idx = 0;
    endfunction

    function automatic void model_step(input logic [2:0] v, input logic [2:0] r,
                                       input logic [11:0] d, input logic clr);
        bit ed[3], edt[3], eto[3];
        int dc[3];
        for (int c = 0; c < 3; c++) begin
            dc[c]  = int'(d[c*4 +: 4]);
            ed[c]  = (m_stall_len[c] > 0) && !v[c];
            edt[c] = (m_stall_len[c] > 0) && v[c] && (dc[c] != m_held[c]);
            eto[c] = v[c] && !r[c] && (m_stall_len[c] + 1 == TIMEOUT);
        end
        if (clr) begin
            for (int c = 0; c < 3; c++) begin
                m_drop[c] = 0;
                m_data[c] = 0;
                m_to[c]   = 0;
                m_cnt[c]  = 0;
            end
            m_fe_v   = 0;
            m_fe_idx = 0;
        end else begin
            for (int c = 0; c < 3; c++) begin
                m_drop[c] |= ed[c];
                m_data[c] |= edt[c];
                m_to[c]   |= eto[c];
                if (v[c] && r[c] && m_cnt[c] < CNT_MAX) m_cnt[c]++;
                if (!m_fe_v && (ed[c] || edt[c] || eto[c])) begin
                    m_fe_v   = 1;
                    m_fe_idx = c;
                end
            end
        end
        for (int c = 0; c < 3; c++) begin
            if (v[c] && !r[c]) begin
                if (m_stall_len[c] == 0) m_held[c] = dc[c];
                m_stall_len[c]++;
            end else begin
                m_stall_len[c] = 0;
            end
        end
    endfunction

    function automatic logic [21:0] exp_vec();
        logic [2:0] dr, da, to;
        logic [8:0] xc;
        logic [1:0] idx;
        for (int c = 0; c < 3; c++) begin
            dr[c]          = m_drop[c];
            da[c]          = m_data[c];
            to[c]          = m_to[c];
            xc[c*3 +: 3]   = 3'(m_cnt[c]);
        end
        idx = 2'(m_fe_idx);
        return {dr, da, to, |{dr, da, to}, m_fe_v, idx, xc};
    endfunction

    function automatic logic [21:0] obs_vec();
        return {err_drop, err_data, err_timeout, any_err, first_err_ch, xfer_count};
    endfunction

    task automatic cycle(input logic [2:0] v, input logic [2:0] r, input logic [11:0] d,
                         input logic clr);
        ch_valid = v;
        ch_ready = r;
        ch_data  = d;
        clear    = clr;
        @(posedge CLK);
        model_step(v, r, d, clr);
        #1;
    endtask

    task automatic do_reset();
        ASYNCRESET = 1'b1;
        ch_valid   = '0;
        ch_ready   = '0;
        ch_data    = '0;
        clear      = 1'b0;
        model_reset();
        @(negedge CLK);
        ASYNCRESET = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_tests++;
        if (obs_vec() !== 22'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got %h expected 0", obs_vec());
        end
        do_reset();
        cycle(3'b000, 3'b000, 12'h000, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL reset_idle: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_stall_then_xfer();
        do_reset();
        repeat (3) cycle(3'b001, 3'b000, 12'h00A, 1'b0);
        cycle(3'b001, 3'b001, 12'h00A, 1'b0);
        n_tests++;
        if (xfer_count[2:0] !== 3'd1) begin
            n_fail++;
            $display("FAIL stall_xfer_count: got %0d expected 1", xfer_count[2:0]);
        end
        n_tests++;
        if (any_err !== 1'b0) begin
            n_fail++;
            $display("FAIL stall_xfer_any_err: got %b expected 0", any_err);
        end
        cycle(3'b000, 3'b000, 12'h000, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL stall_xfer_model: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_data_change();
        do_reset();
        cycle(3'b010, 3'b000, 12'h030, 1'b0);
        cycle(3'b010, 3'b000, 12'h050, 1'b0);
        n_tests++;
        if (err_data !== 3'b010) begin
            n_fail++;
            $display("FAIL data_change_err: got %b expected 010", err_data);
        end
        n_tests++;
        if (first_err_ch !== 3'b101) begin
            n_fail++;
            $display("FAIL data_change_first: got %b expected 101", first_err_ch);
        end
        cycle(3'b010, 3'b010, 12'h050, 1'b0);
        cycle(3'b000, 3'b000, 12'h000, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL data_change_model: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_drop();
        do_reset();
        cycle(3'b101, 3'b000, 12'h102, 1'b0);
        cycle(3'b000, 3'b000, 12'h000, 1'b0);
        n_tests++;
        if (err_drop !== 3'b101) begin
            n_fail++;
            $display("FAIL drop_err: got %b expected 101", err_drop);
        end
        n_tests++;
        if (first_err_ch !== 3'b100) begin
            n_fail++;
            $display("FAIL drop_first: got %b expected 100", first_err_ch);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        for (int k = 1; k <= 6; k++) begin
            cycle(3'b001, 3'b000, 12'h007, 1'b0);
            if (k == 3 || k == 4 || k == 6) begin
                n_tests++;
                if (err_timeout[0] !== (k >= 4)) begin
                    n_fail++;
                    $display("FAIL timeout_k%0d: got %b expected %b", k, err_timeout[0], k >= 4);
                end
            end
        end
        // Clear mid-stall: a stall already past TIMEOUT must not fire again.
        cycle(3'b001, 3'b000, 12'h007, 1'b1);
        cycle(3'b001, 3'b000, 12'h007, 1'b0);
        n_tests++;
        if (err_timeout !== 3'b000) begin
            n_fail++;
            $display("FAIL timeout_once: got %b expected 000", err_timeout);
        end
        cycle(3'b001, 3'b001, 12'h007, 1'b0);
        n_tests++;
        if (obs_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL timeout_model: got %h expected %h", obs_vec(), exp_vec());
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int k = 1; k <= 9; k++) begin
            cycle(3'b010, 3'b010, 12'(($urandom & 32'hF) << 4), 1'b0);
            if (k == 6 || k == 7 || k == 9) begin
                n_tests++;
                if (xfer_count[5:3] !== 3'(k > 7 ? 7 : k)) begin
                    n_fail++;
                    $display("FAIL b2b_count_k%0d: got %0d expected %0d", k, xfer_count[5:3],
                             k > 7 ? 7 : k);
                end
            end
        end
        cycle(3'b001, 3'b000, 12'h000, 1'b0);
        cycle(3'b000, 3'b000, 12'h000, 1'b1);
        n_tests++;
        if (obs_vec() !== 22'd0) begin
            n_fail++;
            $display("FAIL clear_all: got %h expected 0", obs_vec());
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(3'b001, 3'b000, 12'h000, 1'b0);
        cycle(3'b000, 3'b000, 12'h000, 1'b0);
        cycle(3'b100, 3'b000, 12'h300, 1'b0);
        cycle(3'b100, 3'b000, 12'h300, 1'b0);
        n_tests++;
        if (err_drop !== 3'b001) begin
            n_fail++;
            $display("FAIL pre_reset_drop: got %b expected 001", err_drop);
        end
        #2;
        ASYNCRESET = 1'b1;
        #1;
        n_tests++;
        if (obs_vec() !== 22'd0) begin
            n_fail++;
            $display("FAIL async_reset_now: got %h expected 0", obs_vec());
        end
        model_reset();
        @(negedge CLK);
        ASYNCRESET = 1'b0;
        repeat (3) cycle(3'b100, 3'b000, 12'h300, 1'b0);
        cycle(3'b100, 3'b100, 12'h300, 1'b0);
        n_tests++;
        if ({err_drop, err_data, err_timeout, any_err} !== 10'd0) begin
            n_fail++;
            $display("FAIL post_reset_errs: got %b expected 0",
                     {err_drop, err_data, err_timeout, any_err});
        end
        n_tests++;
        if (xfer_count[8:6] !== 3'd1) begin
            n_fail++;
            $display("FAIL post_reset_count: got %0d expected 1", xfer_count[8:6]);
        end
    endtask

    task automatic test_random();
        logic [2:0]  v, r;
        logic [11:0] d;
        logic        clr;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = 3'($urandom);
            for (int c = 0; c < 3; c++) begin
                if (m_stall_len[c] > 0) begin
                    v[c]         = ($urandom_range(0, 7) != 0);
                    d[c*4 +: 4]  = ($urandom_range(0, 7) != 0) ? 4'(m_held[c]) : 4'($urandom);
                end else begin
                    v[c]         = 1'($urandom);
                    d[c*4 +: 4]  = 4'($urandom);
                end
            end
            clr = ($urandom_range(0, 29) == 0);
            cycle(v, r, d, clr);
            n_tests++;
            if (obs_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random_cycle%0d: got %h expected %h", n, obs_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_stall_then_xfer();
        test_data_change();
        test_drop();
        test_timeout();
        test_back_to_back();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
